// File: rtl/param_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub ops, iterative shift-add multiply
// and restoring divide, one request at a time through a start/ready handshake.
module param_alu #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             start,
  input  logic [2:0]       opcode,
  output logic             ready,
  output logic [2*W-1:0]   result,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_o
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // done pulses for one cycle with result/err valid, and ready is already high then.

  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [W:0]       sum_w, dif_w;
  logic [2*W-1:0]   mul_acc;
  logic [W:0]       rem_sh, div_diff;
  logic             div_ge;
  logic [W-1:0]     rem_nx, quo_nx;
  logic             last_iter;

  assign sum_w     = {1'b0, A} + {1'b0, B};
  assign dif_w     = {1'b0, A} - {1'b0, B};
  assign mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // Restoring step: bring in the next dividend bit, keep the difference if no borrow.
  assign rem_sh    = {rem_q, quo_q[W-1]};
  assign div_diff  = rem_sh - {1'b0, b_q};
  assign div_ge    = ~div_diff[W];
  assign rem_nx    = div_ge ? div_diff[W-1:0] : rem_sh[W-1:0];
  assign quo_nx    = {quo_q[W-2:0], div_ge};
  assign last_iter = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (opcode)
            OP_ADD: begin
              result_d = {{(W-1){1'b0}}, sum_w};
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            OP_SUB: begin
              result_d = {{(W-1){1'b0}}, dif_w};
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            OP_AND, OP_XOR, OP_OR: begin
              if (opcode == OP_AND)      result_d = {{W{1'b0}}, A & B};
              else if (opcode == OP_XOR) result_d = {{W{1'b0}}, A ^ B};
              else                       result_d = {{W{1'b0}}, A | B};
              done_d = 1'b1;
              err_d  = 1'b0;
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{W{1'b0}}, A};
              mplier_d = B;
              cnt_d    = '0;
              state_d  = MUL_RUN;
            end
            OP_DIV: begin
              if (B == '0) begin
                result_d = {A, {W{1'b1}}};
                done_d   = 1'b1;
                err_d    = 1'b1;
              end else begin
                rem_d   = '0;
                quo_d   = A;
                b_d     = B;
                cnt_d   = '0;
                state_d = DIV_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      MUL_RUN: begin
        acc_d    = mul_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          result_d = mul_acc;
          done_d   = 1'b1;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      DIV_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          result_d = {rem_nx, quo_nx};
          done_d   = 1'b1;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign result  = result_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule
